// File: rtl/ce_pkg.sv
// rtl/ce_pkg.sv - shared states, counter width and defaults for the stage handshake controller
package ce_pkg;

  localparam int CE_CNT_W         = 4;
  localparam int CE_DELAY_DEFAULT = 1;
  localparam int CE_SYNC_DEFAULT  = 2;

  typedef enum logic {
    U_IDLE,
    U_ACK
  } u_state_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_DELAY,
    D_REQ,
    D_RTZ
  } d_state_e;

endpackage

// File: rtl/ce_sync_n.sv
// rtl/ce_sync_n.sv - N-flop level synchroniser with synchronous active-high clear
module ce_sync_n #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/ce_handshake_ctrl.sv
// rtl/ce_handshake_ctrl.sv - one-token 4-phase stage controller with capture pulse and token delete
// Optional CE_SYNC_EN: route CE_Send_in / CE_Ack_in through SYNC_STAGES-flop synchronisers.
module ce_handshake_ctrl
  import ce_pkg::*;
#(
  parameter int DELAY_CYCLES = CE_DELAY_DEFAULT,
  parameter int SYNC_STAGES  = CE_SYNC_DEFAULT
) (
  input  logic CLK,
  input  logic MR,
  input  logic CE_Send_in,
  input  logic CE_Ack_in,
  input  logic Exb,
  output logic CE_Ack_out,
  output logic CE_Send_out,
  output logic CE_CP
);

  localparam logic [CE_CNT_W-1:0] DELAY_LD = CE_CNT_W'(DELAY_CYCLES);

  if (SYNC_STAGES < 2) begin : g_sync_depth_check
    $error("SYNC_STAGES must be at least 2");
  end

  logic send_in_s;
  logic ack_in_s;

`ifdef CE_SYNC_EN
  ce_sync_n #(.N(SYNC_STAGES)) u_sync_send (
    .clk (CLK),
    .rst (MR),
    .d   (CE_Send_in),
    .q   (send_in_s)
  );

  ce_sync_n #(.N(SYNC_STAGES)) u_sync_ack (
    .clk (CLK),
    .rst (MR),
    .d   (CE_Ack_in),
    .q   (ack_in_s)
  );
`else
  assign send_in_s = CE_Send_in;
  assign ack_in_s  = CE_Ack_in;
`endif

  u_state_e            u_state_q, u_state_d;
  d_state_e            d_state_q, d_state_d;
  logic [CE_CNT_W-1:0] cnt_q, cnt_d;
  logic                ack_out_q, ack_out_d;
  logic                send_out_q, send_out_d;
  logic                cp_q, cp_d;
  logic                capture;

  // A token is only taken when both sides are idle: the stage holds one token.
  assign capture = (u_state_q == U_IDLE) && (d_state_q == D_IDLE) && send_in_s;

  always_comb begin
    u_state_d = u_state_q;
    d_state_d = d_state_q;
    cnt_d     = cnt_q;
    cp_d      = 1'b0;

    case (u_state_q)
      U_IDLE: begin
        if (capture) begin
          u_state_d = U_ACK;
          cp_d      = 1'b1;
        end
      end
      U_ACK: begin
        if (!send_in_s) begin
          u_state_d = U_IDLE;
        end
      end
      default: u_state_d = U_IDLE;
    endcase

    case (d_state_q)
      D_IDLE: begin
        if (capture && !Exb) begin
          if (DELAY_LD == '0) begin
            d_state_d = D_REQ;
          end else begin
            d_state_d = D_DELAY;
            cnt_d     = DELAY_LD;
          end
        end
      end
      D_DELAY: begin
        if (cnt_q == '0) begin
          d_state_d = D_REQ;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      D_REQ: begin
        if (ack_in_s) begin
          d_state_d = D_RTZ;
        end
      end
      D_RTZ: begin
        if (!ack_in_s) begin
          d_state_d = D_IDLE;
        end
      end
      default: d_state_d = D_IDLE;
    endcase

    ack_out_d  = (u_state_d == U_ACK);
    send_out_d = (d_state_d == D_REQ);
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      u_state_q  <= U_IDLE;
      d_state_q  <= D_IDLE;
      cnt_q      <= '0;
      ack_out_q  <= 1'b0;
      send_out_q <= 1'b0;
      cp_q       <= 1'b0;
    end else begin
      u_state_q  <= u_state_d;
      d_state_q  <= d_state_d;
      cnt_q      <= cnt_d;
      ack_out_q  <= ack_out_d;
      send_out_q <= send_out_d;
      cp_q       <= cp_d;
    end
  end

  assign CE_Ack_out  = ack_out_q;
  assign CE_Send_out = send_out_q;
  assign CE_CP       = cp_q;

endmodule

// File: tb/tb_ce_handshake_ctrl.sv
// tb/tb_ce_handshake_ctrl.sv - vector-table and sequence checks for ce_handshake_ctrl (default build)
module tb_ce_handshake_ctrl;

  logic CLK = 1'b0;
  logic MR = 1'b1;
  logic CE_Send_in = 1'b0;
  logic CE_Ack_in = 1'b0;
  logic Exb = 1'b0;
  logic CE_Ack_out;
  logic CE_Send_out;
  logic CE_CP;

  int checks = 0;
  int errors = 0;

  ce_handshake_ctrl #(.DELAY_CYCLES(1), .SYNC_STAGES(2)) dut (
    .CLK         (CLK),
    .MR          (MR),
    .CE_Send_in  (CE_Send_in),
    .CE_Ack_in   (CE_Ack_in),
    .Exb         (Exb),
    .CE_Ack_out  (CE_Ack_out),
    .CE_Send_out (CE_Send_out),
    .CE_CP       (CE_CP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic mr;
    logic s;
    logic a;
    logic e;
    logic ack;
    logic so;
    logic cp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic mr, input logic s, input logic a, input logic e,
                              input logic ack, input logic so, input logic cp);
    vec_t v;
    v.mr = mr; v.s = s; v.a = a; v.e = e;
    v.ack = ack; v.so = so; v.cp = cp;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are read at the same point.
  task automatic step(input logic mr, input logic s, input logic a, input logic e);
    MR = mr; CE_Send_in = s; CE_Ack_in = a; Exb = e;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cp_seen;
    int lat;

    // mr s a e | ack so cp  (outputs after the edge that samples the inputs)
    add(1,1,1,0, 0,0,0);
    add(1,1,1,0, 0,0,0);
    add(0,0,0,0, 0,0,0);
    add(0,0,0,0, 0,0,0);
    // normal token, DELAY_CYCLES=1
    add(0,1,0,0, 1,0,1);
    add(0,1,0,0, 1,0,0);
    add(0,0,0,0, 0,1,0);
    add(0,0,0,0, 0,1,0);
    add(0,0,1,0, 0,0,0);
    add(0,0,1,0, 0,0,0);
    add(0,0,0,0, 0,0,0);
    // Send_in held high 10 cycles: one CP only
    add(0,1,0,0, 1,0,1);
    add(0,1,0,0, 1,0,0);
    add(0,1,0,0, 1,1,0);
    for (int i = 0; i < 7; i++) add(0,1,0,0, 1,1,0);
    add(0,0,0,0, 0,1,0);
    add(0,0,1,0, 0,0,0);
    add(0,0,0,0, 0,0,0);
    // Ack_in high during D_IDLE and D_DELAY is ignored
    add(0,0,1,0, 0,0,0);
    add(0,1,1,0, 1,0,1);
    add(0,0,1,0, 0,0,0);
    add(0,0,1,0, 0,1,0);
    add(0,0,1,0, 0,0,0);
    add(0,0,0,0, 0,0,0);
    // MR during D_REQ, then idle capture, then MR during D_DELAY drops the token
    add(0,1,0,0, 1,0,1);
    add(0,0,0,0, 0,0,0);
    add(0,0,0,0, 0,1,0);
    add(1,0,0,0, 0,0,0);
    add(0,0,0,0, 0,0,0);
    add(0,1,0,0, 1,0,1);
    add(1,0,0,0, 0,0,0);
    add(0,0,0,0, 0,0,0);
    add(0,0,0,0, 0,0,0);
    add(0,0,0,0, 0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].mr, vecs[i].s, vecs[i].a, vecs[i].e);
      check($sformatf("vec%0d_ack_out", i), CE_Ack_out, vecs[i].ack);
      check($sformatf("vec%0d_send_out", i), CE_Send_out, vecs[i].so);
      check($sformatf("vec%0d_cp", i), CE_CP, vecs[i].cp);
    end

    // Deleted token: pulse and ack, but no downstream request for 20 cycles
    step(0, 1, 0, 1);
    check("exb_cp", CE_CP, 1'b1);
    check("exb_ack_out", CE_Ack_out, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, (i == 0) ? 1'b1 : 1'b0);
      check($sformatf("exb_send_out_c%0d", i), CE_Send_out, 1'b0);
    end
    step(0, 1, 0, 0);
    check("after_exb_cp", CE_CP, 1'b1);
    step(0, 0, 0, 0);
    check("after_exb_so_e1", CE_Send_out, 1'b0);
    step(0, 0, 0, 0);
    check("after_exb_so_e2", CE_Send_out, 1'b1);
    step(0, 0, 1, 0);
    check("after_exb_so_drop", CE_Send_out, 1'b0);
    step(0, 0, 0, 0);

    // Token held downstream blocks a second capture until the 4-phase return completes
    step(0, 1, 0, 0);
    check("hold_cp1", CE_CP, 1'b1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("hold_so", CE_Send_out, 1'b1);
    cp_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
      if (CE_CP) cp_seen++;
    end
    step(0, 1, 1, 0);
    if (CE_CP) cp_seen++;
    step(0, 1, 1, 0);
    if (CE_CP) cp_seen++;
    check("hold_no_cp_while_busy", (cp_seen == 0), 1'b1);
    check("hold_ack_out_low", CE_Ack_out, 1'b0);
    lat = 0;
    for (int i = 1; i <= 4 && lat == 0; i++) begin
      step(0, 1, 0, 0);
      if (CE_CP) lat = i;
    end
    check("hold_cp_seen_in_budget", (lat != 0), 1'b1);
    check("hold_cp_latency_2", (lat == 2), 1'b1);
    check("hold_ack_out_after", CE_Ack_out, 1'b1);
    step(0, 0, 0, 0);
    check("hold_ack_rtz", CE_Ack_out, 1'b0);
    step(0, 0, 0, 0);
    check("hold_so2", CE_Send_out, 1'b1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("hold_final_so", CE_Send_out, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
